amoa_rt8_acc_sched: RTL

Job scheduler and accumulator for one shared 8-operand, 8-bit approximate adder tree (amoa_8x8p2_rt8 family, 2 register stages, 11-bit sum). Two requesters stream multi-beat jobs; each beat carries 8 operands. The block grants whole jobs round-robin, feeds beats to the tree, tracks in-flight beats through the tree latency, accumulates the tree sums per job, and returns one result per job over a valid/ready port. It performs no error correction; results are exactly what the approximate tree produces.

---
 rtl/amoa_rt8_acc_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/amoa_rt8_acc_sched.sv
// amoa_rt8_acc_sched: job scheduler and accumulator in front of one shared
// 8-operand approximate adder tree with LAT register stages. Two requesters
// stream multi-beat jobs. Whole jobs are granted round-robin. Tags follow each
// beat through the tree latency, and the tree sums of a job are accumulated
// into one result.
module amoa_rt8_acc_sched #(
  parameter int LAT   = 2,
  parameter int ACC_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [63:0]       req0_data_i,
  input  logic              req0_last_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [63:0]       req1_data_i,
  input  logic              req1_last_i,
  output logic [63:0]       tree_x_o,
  input  logic [10:0]       tree_summ_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [ACC_W-1:0]  res_sum_o,
  output logic              res_id_o,
  output logic [8:0]        res_beats_o,
  output logic              res_ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // One tag per tree slot. It says whether the slot carries a beat and
  // where that beat sits inside its job.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // requester that owns the current job
  logic              rr_q, rr_d;         // preferred requester on a tie
  logic              first_q;            // next accepted beat opens the job
  tag_t              tag_q [LAT];
  tag_t              tag_in;
  tag_t              tag_out;
  logic [ACC_W-1:0]  acc_q;
  logic [8:0]        beats_q;

  logic              own_valid;
  logic              own_last;
  logic [63:0]       own_data;
  logic              accept;

  assign own_valid = owner_q ? req1_valid_i : req0_valid_i;
  assign own_last  = owner_q ? req1_last_i  : req0_last_i;
  assign own_data  = owner_q ? req1_data_i  : req0_data_i;
  assign tag_out   = tag_q[LAT-1];

  // Next-state, arbitration and handshake decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    accept       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          state_d = S_ISSUE;
          if (req0_valid_i && req1_valid_i) begin
            owner_d = rr_q;
            rr_d    = ~rr_q;
          end else begin
            owner_d = req1_valid_i;
          end
        end
      end
      S_ISSUE: begin
        // Ready is held low while reset is asserted, so no beat can be
        // taken in a cycle whose state is about to be discarded.
        if (!rst_i) begin
          req0_ready_o = ~owner_q;
          req1_ready_o = owner_q;
          accept       = own_valid;
        end
        if (accept && own_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tag_out.valid && tag_out.last) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands reach the tree only for accepted beats; otherwise zeros.
  always_comb begin
    tree_x_o = accept ? own_data : 64'd0;
    tag_in   = '0;
    if (accept) begin
      tag_in.valid = 1'b1;
      tag_in.first = first_q;
      tag_in.last  = own_last;
    end
  end

  // Control state: FSM, owner, round-robin pointer and first-beat flag.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      if (state_q == S_IDLE && state_d == S_ISSUE) first_q <= 1'b1;
      else if (accept)                             first_q <= 1'b0;
    end
  end

  // Tag shift register, aligned with the tree pipeline.
  always_ff @(posedge clk_i) begin
    // NOTE: the tag array is reset on purpose; clearing it is what makes
    // tree output still in flight at reset be ignored.
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Accumulate tree sums as their tags emerge; a first tag restarts the sum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (tag_out.valid) begin
      acc_q <= (tag_out.first ? '0 : acc_q) + ACC_W'(tree_summ_i);
    end
  end

  // Count accepted beats of the current job, saturating at 511.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_q <= 9'd0;
    end else if (accept) begin
      if (first_q)                 beats_q <= 9'd1;
      else if (beats_q != 9'd511)  beats_q <= beats_q + 9'd1;
    end
  end

  // The result fields are the live job registers. None of them moves while
  // in RESULT, because no beat is accepted and no valid tag remains.
  assign res_valid_o = (state_q == S_RESULT);
  assign res_sum_o   = acc_q;
  assign res_id_o    = owner_q;
  assign res_beats_o = beats_q;
  assign res_ovf_o   = (beats_q > 9'd256);

endmodule
